// File: rtl/demux8_slice.sv
// demux8_slice: 1-to-8 valid/ready demultiplexer with a one-entry buffer per channel.
// A broadcast beat is written to all eight channels once every channel can take it.
module demux8_slice #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_sel,
  input  logic                    in_bcast,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic [7:0]              out_valid,
  input  logic [7:0]              out_ready,
  output logic [8*DATA_WIDTH-1:0] out_data,
  output logic                    busy
);

  logic [7:0]                 full_q;
  logic [7:0]                 full_d;
  logic [7:0][DATA_WIDTH-1:0] buf_q;
  logic [7:0][DATA_WIDTH-1:0] buf_d;
  logic                       busy_q;
  logic                       busy_d;

  logic [7:0] free_s;
  logic [7:0] drain_s;
  logic [7:0] target_s;
  logic [7:0] write_s;
  logic       sel_free_s;
  logic       in_ready_s;
  logic       accept_s;

  // Next-state: a channel is free when empty or being drained this cycle,
  // which lets a single-entry buffer sustain one beat per cycle.
  always_comb begin
    free_s  = ~full_q | out_ready;
    drain_s = full_q & out_ready;
    if (in_bcast) begin
      target_s   = 8'hFF;
      sel_free_s = &free_s;
    end else begin
      target_s   = 8'h01 << in_sel;
      sel_free_s = free_s[in_sel];
    end
    in_ready_s = rst_n & sel_free_s;
    accept_s   = in_valid & in_ready_s;
    if (accept_s) begin
      write_s = target_s;
    end else begin
      write_s = 8'h00;
    end
    full_d = (full_q & ~drain_s) | write_s;
    buf_d  = buf_q;
    for (int i = 0; i < 8; i++) begin
      if (write_s[i]) begin
        buf_d[i] = in_data;
      end else begin
        buf_d[i] = buf_q[i];
      end
    end
    busy_d = |full_d;
  end

  // State registers; reset discards any buffered beats immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 8'h00;
      buf_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      full_q <= full_d;
      buf_q  <= buf_d;
      busy_q <= busy_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = full_q;
  assign out_data  = buf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_demux8_slice.sv
// Scoreboard bench for demux8_slice: per-channel expected-beat queues are filled on
// accept and emptied by a monitor as beats are consumed; directed cases plus random traffic.
module tb_demux8_slice;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_bcast = 1'b0;
  logic [2:0]      in_sel = 3'd0;
  logic [DW-1:0]   in_data = '0;
  logic            in_ready;
  logic [7:0]      out_valid;
  logic [7:0]      out_ready = 8'h00;
  logic [8*DW-1:0] out_data;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: each channel is a queue of beats it currently holds (capacity one).
  logic [DW-1:0] exp_q [8][$];
  logic [7:0]    m_occ;
  logic [7:0]    m_free;
  logic          m_rdy;

  demux8_slice #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_bcast(in_bcast), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor then scoreboard push, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) exp_q[i].delete();
    end else begin
      for (int i = 0; i < 8; i++) begin
        m_occ[i]  = (exp_q[i].size() != 0);
        m_free[i] = !m_occ[i] || out_ready[i];
      end
      m_rdy = in_bcast ? (&m_free) : m_free[in_sel];
      check("out_valid", {24'd0, out_valid}, {24'd0, m_occ});
      check("busy", {31'd0, busy}, {31'd0, |m_occ});
      check("in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
      for (int i = 0; i < 8; i++) begin
        if (m_occ[i]) begin
          check($sformatf("out_data[%0d]", i), out_data[i*DW +: DW], exp_q[i][0]);
          if (out_ready[i]) void'(exp_q[i].pop_front());
        end
      end
      if (in_valid && m_rdy) begin
        for (int i = 0; i < 8; i++) begin
          if (in_bcast || (in_sel == 3'(i))) exp_q[i].push_back(in_data);
        end
      end
    end
  end

  // Present a beat and hold it until the slice takes it or the budget runs out.
  task automatic send(input logic [2:0] s, input logic b, input logic [DW-1:0] d,
                      input int budget, output bit ok);
    in_valid = 1'b1; in_sel = s; in_bcast = b; in_data = d; ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_bcast = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    bit ok;
    bit accepted;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", {24'd0, out_valid}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Asynchronous reset in the middle of a stream
    out_ready = 8'h00;
    send(3'd2, 1'b0, 32'h0000_0C02, 4, ok);
    check("fill ch2", {31'd0, ok}, 32'd1);
    send(3'd5, 1'b0, 32'h0000_0C05, 4, ok);
    check("fill ch5", {31'd0, ok}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async rst out_valid", {24'd0, out_valid}, 32'd0);
    check("async rst data ch2", out_data[2*DW +: DW], 32'd0);
    check("async rst data ch5", out_data[5*DW +: DW], 32'd0);
    check("async rst busy", {31'd0, busy}, 32'd0);
    check("async rst in_ready", {31'd0, in_ready}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Routing to each channel
    out_ready = 8'hFF;
    for (int s = 0; s < 8; s++) begin
      send(3'(s), 1'b0, 32'hA0 + 32'(s), 4, ok);
      check("route accept", {31'd0, ok}, 32'd1);
    end
    idle(2);
    for (int i = 0; i < 8; i++)
      check($sformatf("route hold ch%0d", i), out_data[i*DW +: DW], 32'hA0 + 32'(i));

    // Backpressure on channel 3
    out_ready = 8'hF7;
    send(3'd3, 1'b0, 32'h11, 4, ok);
    check("bp first accept", {31'd0, ok}, 32'd1);
    in_valid = 1'b1; in_sel = 3'd3; in_data = 32'h22;
    @(negedge clk);
    check("bp ch3 stalled", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    send(3'd4, 1'b0, 32'h33, 4, ok);
    check("bp ch4 accept", {31'd0, ok}, 32'd1);
    out_ready = 8'hFF;
    send(3'd3, 1'b0, 32'h22, 4, ok);
    check("bp second accept", {31'd0, ok}, 32'd1);
    idle(2);

    // Drain and refill on channel 6 every cycle
    out_ready = 8'h00;
    send(3'd6, 1'b0, 32'h1, 4, ok);
    check("refill prime", {31'd0, ok}, 32'd1);
    out_ready = 8'h40;
    in_valid = 1'b1; in_sel = 3'd6; in_bcast = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_data = 32'h100 + 32'(k);
      @(negedge clk);
      check("refill in_ready", {31'd0, in_ready}, 32'd1);
      check("refill valid6", {31'd0, out_valid[6]}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 8'hFF;
    idle(2);

    // Broadcast blocked by a stalled channel, then released
    out_ready = 8'h00;
    send(3'd1, 1'b0, 32'h55, 4, ok);
    check("bcast prime ch1", {31'd0, ok}, 32'd1);
    in_valid = 1'b1; in_bcast = 1'b1; in_sel = 3'd0; in_data = 32'hDEADBEEF;
    @(negedge clk);
    check("bcast blocked", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bcast no write", {24'd0, out_valid}, 32'h02);
    @(posedge clk); #1;
    out_ready = 8'h02;
    @(negedge clk);
    check("bcast released", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_bcast = 1'b0; out_ready = 8'h00;
    @(negedge clk);
    check("bcast all valid", {24'd0, out_valid}, 32'hFF);
    for (int i = 0; i < 8; i++)
      check($sformatf("bcast data ch%0d", i), out_data[i*DW +: DW], 32'hDEADBEEF);
    @(posedge clk); #1;

    // Idle with every consumer ready
    out_ready = 8'hFF;
    idle(3);
    @(negedge clk);
    check("idle out_valid", {24'd0, out_valid}, 32'd0);
    check("idle busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // Random traffic; a presented beat is held until accepted
    accepted = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      out_ready = 8'($urandom);
      if (accepted || !in_valid) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_sel   = 3'($urandom_range(0, 7));
        in_bcast = ($urandom_range(0, 7) == 0);
        in_data  = $urandom;
      end
      @(negedge clk);
      accepted = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_bcast = 1'b0;
    out_ready = 8'hFF;
    idle(3);
    @(negedge clk);
    check("final drained", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
